// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, controller states
// and the access-size decode used by both the controller and the load aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    ISSUE_HI,
    CAPTURE,
    RESP
  } lsu_state_t;

  // Access size in bytes; the unused code 11 yields 0 so it can never enable a lane.
  function automatic logic [2:0] size_bytes(input logic [1:0] size_code);
    case (size_code)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      2'b10:   size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) funct3_legal = funct3 inside {F3_B, F3_H, F3_W};
    else    funct3_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts a byte/half/word from a two-word little-endian window and extends it.
// Purely combinational so the pipeline forwarding path can share it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(window >> {off, 3'b000});
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store requester for a four-lane byte-enabled data memory; word-crossing
// accesses are split into a low-word and a high-word memory cycle.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_WIDTH    = 4,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [ADDRESS_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       resp_valid,
  output logic                       resp_err,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic [3:0]                 mem_byteEnable,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_din,
  input  logic [DATA_WIDTH-1:0]      mem_dout
);

  lsu_state_t               state;
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [1:0]               off_q;
  logic [ADDRESS_WIDTH-1:0] word_lo_q;
  logic [7:0]               be8_q;
  logic [2*DATA_WIDTH-1:0]  data64_q;
  logic                     split_q;
  logic [DATA_WIDTH-1:0]    lo_buf;

  logic [2:0]               req_size;
  logic [7:0]               req_be8;
  logic [2*DATA_WIDTH-1:0]  lane_mask;
  logic [2*DATA_WIDTH-1:0]  req_data64;
  logic                     req_split;
  logic                     req_fault;

  logic [2*DATA_WIDTH-1:0]  window;
  logic [DATA_WIDTH-1:0]    align_data;

  // Request geometry only feeds the latch registers, never an output directly.
  always_comb begin
    req_size  = size_bytes(req_funct3[1:0]);
    req_be8   = ((8'd1 << req_size) - 8'd1) << req_addr[1:0];
    for (int k = 0; k < 8; k++) lane_mask[8*k +: 8] = {8{req_be8[k]}};
    req_data64 = ({{DATA_WIDTH{1'b0}}, req_wdata} << {req_addr[1:0], 3'b000}) & lane_mask;
    req_split  = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    req_fault  = !funct3_legal(req_we, req_funct3) || (req_split && !ALLOW_MISALIGNED);
  end

  assign window = split_q ? {mem_dout, lo_buf} : {{DATA_WIDTH{1'b0}}, mem_dout};

  lsu_load_align u_align (
    .window (window),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      word_lo_q  <= '0;
      be8_q      <= '0;
      data64_q   <= '0;
      split_q    <= 1'b0;
      lo_buf     <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            word_lo_q <= req_addr[ADDRESS_WIDTH+1:2];
            be8_q     <= req_be8;
            data64_q  <= req_data64;
            split_q   <= req_split;
            resp_err  <= req_fault;
            state     <= req_fault ? RESP : ISSUE_LO;
          end
        end
        ISSUE_LO: state <= split_q ? ISSUE_HI : (we_q ? RESP : CAPTURE);
        ISSUE_HI: begin
          if (!we_q) lo_buf <= mem_dout;
          state <= we_q ? RESP : CAPTURE;
        end
        CAPTURE: begin
          resp_rdata <= align_data;
          state      <= RESP;
        end
        RESP: begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Memory side decodes from state and latched request only; the high word wraps.
  always_comb begin
    mem_addr       = word_lo_q;
    mem_byteEnable = '0;
    mem_din        = '0;
    case (state)
      ISSUE_LO: begin
        if (we_q) begin
          mem_byteEnable = be8_q[3:0];
          mem_din        = data64_q[DATA_WIDTH-1:0];
        end
      end
      ISSUE_HI: begin
        mem_addr = word_lo_q + ADDRESS_WIDTH'(1);
        if (we_q) begin
          mem_byteEnable = be8_q[7:4];
          mem_din        = data64_q[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      default: ;
    endcase
  end

endmodule
